// File: rtl/pipe_regs.sv
// ---------------------------------------------------------------------------
// pipe_regs
//   PC register plus the four inter-stage registers (F/D, D/E, E/M, M/W) of a
//   5-stage MIPS pipeline. Stall requests from the hazard unit are turned into
//   register holds and bubble insertion. Stall and bubble performance counters
//   are kept alongside.
//
// Ports
//   clk, reset          : clock, synchronous active-low reset
//   npc, f_instr        : next PC and fetched instruction (F stage)
//   d_rs_val/rt_val/imm : D-stage operands latched into D/E
//   d_a3_in             : D-stage destination register (0 = none)
//   e_alu, e_rt_val_in  : E-stage results latched into E/M
//   m_out_in            : M-stage result latched into M/W
//   fd_stall            : hold PC and F/D
//   de_stall            : bubble into D/E
//   em_stall            : hold PC, F/D, D/E; bubble into E/M
//   pc, d_*, e_*, m_*, w_* : registered stage payloads
//   stall_cnt           : edges seen with fd_stall==1 (wraps)
//   bubble_cnt          : bubbles inserted into D/E or E/M (wraps)
//
// Every output comes straight from a flop; there is no input-to-output path.
// ---------------------------------------------------------------------------
module pipe_regs #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      npc,
    input  logic [31:0]      f_instr,
    input  logic [31:0]      d_rs_val,
    input  logic [31:0]      d_rt_val,
    input  logic [31:0]      d_imm,
    input  logic [4:0]       d_a3_in,
    input  logic [31:0]      e_alu,
    input  logic [31:0]      e_rt_val_in,
    input  logic [31:0]      m_out_in,
    input  logic             fd_stall,
    input  logic             de_stall,
    input  logic             em_stall,
    output logic [31:0]      pc,
    output logic [31:0]      d_instr,
    output logic [31:0]      d_pc,
    output logic [31:0]      e_instr,
    output logic [31:0]      e_pc,
    output logic [31:0]      e_rs_val,
    output logic [31:0]      e_rt_val,
    output logic [31:0]      e_imm,
    output logic [4:0]       e_a3,
    output logic [31:0]      m_instr,
    output logic [31:0]      m_pc,
    output logic [31:0]      m_alu,
    output logic [31:0]      m_rt_val,
    output logic [4:0]       m_a3,
    output logic [31:0]      w_instr,
    output logic [31:0]      w_pc,
    output logic [31:0]      w_data,
    output logic [4:0]       w_a3,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Stage payloads
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fd_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  a3;
    } de_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rt_val;
        logic [4:0]  a3;
    } em_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  a3;
    } mw_t;

    logic [31:0]      pc_q,         pc_d;
    fd_t              fd_q,         fd_d;
    de_t              de_q,         de_d;
    em_t              em_q,         em_d;
    mw_t              mw_q,         mw_d;
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Stall decode. A D/E or E/M request without fd_stall is illegal from the
    // hazard unit; the front end is held anyway so no instruction is lost.
    // em_stall wins over de_stall: D/E keeps its instruction rather than
    // being zeroed, and only the E/M bubble is counted.
    logic hold_fd;
    logic hold_de;
    logic bub_de;
    logic bub_em;

    always_comb begin
        hold_fd = fd_stall | de_stall | em_stall;
        hold_de = em_stall;
        bub_de  = de_stall & ~em_stall;
        bub_em  = em_stall;
    end

    // Next-state logic
    always_comb begin
        pc_d = hold_fd ? pc_q : npc;

        fd_d = fd_q;
        if (!hold_fd) begin
            fd_d.instr = f_instr;
            fd_d.pc    = pc_q;
        end

        de_d = de_q;
        if (bub_de) begin
            // Bubble keeps the PC of the stalled instruction for traceability.
            de_d        = '0;
            de_d.pc     = fd_q.pc;
        end else if (!hold_de) begin
            de_d.instr  = fd_q.instr;
            de_d.pc     = fd_q.pc;
            de_d.rs_val = d_rs_val;
            de_d.rt_val = d_rt_val;
            de_d.imm    = d_imm;
            de_d.a3     = d_a3_in;
        end

        if (bub_em) begin
            em_d        = '0;
            em_d.pc     = de_q.pc;
        end else begin
            em_d.instr  = de_q.instr;
            em_d.pc     = de_q.pc;
            em_d.alu    = e_alu;
            em_d.rt_val = e_rt_val_in;
            em_d.a3     = de_q.a3;
        end

        // M/W always advances; a bubble arrives with a3==0 so no GRF write.
        mw_d.instr = em_q.instr;
        mw_d.pc    = em_q.pc;
        mw_d.data  = m_out_in;
        mw_d.a3    = em_q.a3;

        stall_cnt_d  = stall_cnt_q  + CNT_W'(fd_stall);
        bubble_cnt_d = bubble_cnt_q + CNT_W'(bub_de | bub_em);
    end

    // State registers; reset overrides every stall input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q         <= PC_RESET;
            fd_q         <= '0;
            fd_q.pc      <= PC_RESET;
            de_q         <= '0;
            de_q.pc      <= PC_RESET;
            em_q         <= '0;
            em_q.pc      <= PC_RESET;
            mw_q         <= '0;
            mw_q.pc      <= PC_RESET;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            fd_q         <= fd_d;
            de_q         <= de_d;
            em_q         <= em_d;
            mw_q         <= mw_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Outputs
    assign pc         = pc_q;
    assign d_instr    = fd_q.instr;
    assign d_pc       = fd_q.pc;
    assign e_instr    = de_q.instr;
    assign e_pc       = de_q.pc;
    assign e_rs_val   = de_q.rs_val;
    assign e_rt_val   = de_q.rt_val;
    assign e_imm      = de_q.imm;
    assign e_a3       = de_q.a3;
    assign m_instr    = em_q.instr;
    assign m_pc       = em_q.pc;
    assign m_alu      = em_q.alu;
    assign m_rt_val   = em_q.rt_val;
    assign m_a3       = em_q.a3;
    assign w_instr    = mw_q.instr;
    assign w_pc       = mw_q.pc;
    assign w_data     = mw_q.data;
    assign w_a3       = mw_q.a3;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_regs.sv
// Bench for pipe_regs: directed table + hand sequences, then random stimulus
// against a stage-level reference model. Counters are 4 bits wide so that
// wrap-around is reachable quickly.
module tb_pipe_regs;

    localparam logic [31:0] PC_R = 32'h0000_3000;
    localparam int          CW   = 4;

    logic clk = 1'b0;
    logic reset;
    logic [31:0] npc, f_instr, d_rs_val, d_rt_val, d_imm, e_alu, e_rt_val_in, m_out_in;
    logic [4:0]  d_a3_in;
    logic        fd_stall, de_stall, em_stall;
    logic [31:0] pc, d_instr, d_pc, e_instr, e_pc, e_rs_val, e_rt_val, e_imm;
    logic [31:0] m_instr, m_pc, m_alu, m_rt_val, w_instr, w_pc, w_data;
    logic [4:0]  e_a3, m_a3, w_a3;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    int checks = 0;
    int failures = 0;

    pipe_regs #(.PC_RESET(PC_R), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .npc(npc), .f_instr(f_instr),
        .d_rs_val(d_rs_val), .d_rt_val(d_rt_val), .d_imm(d_imm), .d_a3_in(d_a3_in),
        .e_alu(e_alu), .e_rt_val_in(e_rt_val_in), .m_out_in(m_out_in),
        .fd_stall(fd_stall), .de_stall(de_stall), .em_stall(em_stall),
        .pc(pc), .d_instr(d_instr), .d_pc(d_pc),
        .e_instr(e_instr), .e_pc(e_pc), .e_rs_val(e_rs_val), .e_rt_val(e_rt_val),
        .e_imm(e_imm), .e_a3(e_a3),
        .m_instr(m_instr), .m_pc(m_pc), .m_alu(m_alu), .m_rt_val(m_rt_val), .m_a3(m_a3),
        .w_instr(w_instr), .w_pc(w_pc), .w_data(w_data), .w_a3(w_a3),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each pipeline slot is one record; a,b,c hold the stage-specific data.
    typedef struct {
        logic [31:0] instr, pc, a, b, c;
        logic [4:0]  a3;
    } slot_t;

    slot_t mD, mE, mM, mW;
    logic [31:0] mpc;
    int mstall, mbub;

    function automatic slot_t mk(logic [31:0] i, logic [31:0] p, logic [31:0] a,
                                 logic [31:0] b, logic [31:0] c, logic [4:0] a3);
        slot_t s;
        s.instr = i; s.pc = p; s.a = a; s.b = b; s.c = c; s.a3 = a3;
        return s;
    endfunction

    task automatic model_step();
        slot_t nD, nE, nM, nW;
        logic front_hold;
        if (!reset) begin
            mpc = PC_R;
            mD = mk(0, PC_R, 0, 0, 0, 0); mE = mD; mM = mD; mW = mD;
            mstall = 0; mbub = 0;
            return;
        end
        front_hold = fd_stall || de_stall || em_stall;
        nW = mk(mM.instr, mM.pc, m_out_in, 0, 0, mM.a3);
        if (em_stall) nM = mk(0, mE.pc, 0, 0, 0, 0);
        else          nM = mk(mE.instr, mE.pc, e_alu, e_rt_val_in, 0, mE.a3);
        if (em_stall)      nE = mE;
        else if (de_stall) nE = mk(0, mD.pc, 0, 0, 0, 0);
        else               nE = mk(mD.instr, mD.pc, d_rs_val, d_rt_val, d_imm, d_a3_in);
        nD = front_hold ? mD : mk(f_instr, mpc, 0, 0, 0, 0);
        if (!front_hold) mpc = npc;
        mD = nD; mE = nE; mM = nM; mW = nW;
        if (fd_stall) mstall++;
        if (de_stall || em_stall) mbub++;
    endtask

    task automatic compare_all();
        check("rnd pc", pc, mpc);
        check("rnd d_instr", d_instr, mD.instr);
        check("rnd d_pc", d_pc, mD.pc);
        check("rnd e_instr", e_instr, mE.instr);
        check("rnd e_pc", e_pc, mE.pc);
        check("rnd e_rs_val", e_rs_val, mE.a);
        check("rnd e_rt_val", e_rt_val, mE.b);
        check("rnd e_imm", e_imm, mE.c);
        check("rnd e_a3", 32'(e_a3), 32'(mE.a3));
        check("rnd m_instr", m_instr, mM.instr);
        check("rnd m_pc", m_pc, mM.pc);
        check("rnd m_alu", m_alu, mM.a);
        check("rnd m_rt_val", m_rt_val, mM.b);
        check("rnd m_a3", 32'(m_a3), 32'(mM.a3));
        check("rnd w_instr", w_instr, mW.instr);
        check("rnd w_pc", w_pc, mW.pc);
        check("rnd w_data", w_data, mW.a);
        check("rnd w_a3", 32'(w_a3), 32'(mW.a3));
        check("rnd stall_cnt", 32'(stall_cnt), 32'(mstall % 16));
        check("rnd bubble_cnt", 32'(bubble_cnt), 32'(mbub % 16));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] f_in;
        logic [4:0]  a3_in;
        logic [31:0] ed, ee, em, ew;
        logic [4:0]  ewa3;
    } vec_t;

    vec_t tbl[4];

    task automatic do_reset();
        reset = 1'b0;
        fd_stall = 0; de_stall = 0; em_stall = 0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; npc = 32'h1234; f_instr = 0; d_rs_val = 0; d_rt_val = 0; d_imm = 0;
        d_a3_in = 0; e_alu = 0; e_rt_val_in = 0; m_out_in = 0;
        fd_stall = 1'b1; de_stall = 0; em_stall = 0;

        // Reset held two cycles with a stall pending
        tick(); tick();
        check("reset pc", pc, 32'h3000);
        check("reset d_instr", d_instr, 0);
        check("reset e_instr", e_instr, 0);
        check("reset m_instr", m_instr, 0);
        check("reset w_instr", w_instr, 0);
        check("reset w_pc", w_pc, 32'h3000);
        check("reset e_a3", 32'(e_a3), 0);
        check("reset w_a3", 32'(w_a3), 0);
        check("reset stall_cnt", 32'(stall_cnt), 0);
        check("reset bubble_cnt", 32'(bubble_cnt), 0);
        reset = 1'b1; fd_stall = 0; npc = 32'h3004;
        tick();
        check("post-reset pc", pc, 32'h3004);
        check("post-reset d_pc", d_pc, 32'h3000);

        // Free flow
        tbl[0] = '{32'h11, 5'd0, 32'h11, 32'h0,  32'h0,  32'h0,  5'd0};
        tbl[1] = '{32'h22, 5'd8, 32'h22, 32'h11, 32'h0,  32'h0,  5'd0};
        tbl[2] = '{32'h33, 5'd0, 32'h33, 32'h22, 32'h11, 32'h0,  5'd0};
        tbl[3] = '{32'h44, 5'd0, 32'h44, 32'h33, 32'h22, 32'h11, 5'd8};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            f_instr = tbl[i].f_in; d_a3_in = tbl[i].a3_in; npc = 32'h3004 + 32'(4 * i);
            tick();
            check($sformatf("flow[%0d] d_instr", i), d_instr, tbl[i].ed);
            check($sformatf("flow[%0d] e_instr", i), e_instr, tbl[i].ee);
            check($sformatf("flow[%0d] m_instr", i), m_instr, tbl[i].em);
            check($sformatf("flow[%0d] w_instr", i), w_instr, tbl[i].ew);
            check($sformatf("flow[%0d] w_a3", i), 32'(w_a3), 32'(tbl[i].ewa3));
        end

        // Load-use: bubble into D/E
        do_reset();
        d_a3_in = 0;
        npc = 32'h3004; f_instr = 32'h99; tick();
        npc = 32'h3008; f_instr = 32'hAA; tick();
        fd_stall = 1; de_stall = 1; npc = 32'h300C; f_instr = 32'hCC; tick();
        check("lu pc held", pc, 32'h3008);
        check("lu d_instr held", d_instr, 32'hAA);
        check("lu e_instr bubble", e_instr, 0);
        check("lu e_a3 bubble", 32'(e_a3), 0);
        check("lu e_pc", e_pc, 32'h3004);
        fd_stall = 0; de_stall = 0; d_a3_in = 5'd5; tick();
        check("lu e_instr after", e_instr, 32'hAA);
        check("lu e_a3 after", 32'(e_a3), 5);
        check("lu pc after", pc, 32'h300C);
        check("lu stall_cnt", 32'(stall_cnt), 1);
        check("lu bubble_cnt", 32'(bubble_cnt), 1);

        // E/M stall for two cycles
        do_reset();
        npc = 32'h3004; f_instr = 32'h55; d_a3_in = 0; tick();
        npc = 32'h3008; f_instr = 32'hBB; d_a3_in = 5'd9; tick();
        npc = 32'h300C; f_instr = 32'hCC; d_a3_in = 5'd7; tick();
        fd_stall = 1; em_stall = 1; npc = 32'h3010;
        tick();
        check("em1 e_instr", e_instr, 32'hBB);
        check("em1 m_instr", m_instr, 0);
        check("em1 m_a3", 32'(m_a3), 0);
        check("em1 m_pc", m_pc, 32'h3004);
        check("em1 w_a3", 32'(w_a3), 9);
        check("em1 pc held", pc, 32'h300C);
        tick();
        check("em2 e_instr", e_instr, 32'hBB);
        check("em2 m_instr", m_instr, 0);
        check("em2 w_a3", 32'(w_a3), 0);
        check("em2 bubble_cnt", 32'(bubble_cnt), 2);
        check("em2 stall_cnt", 32'(stall_cnt), 2);

        // All three stalls: em wins, D/E holds
        de_stall = 1; tick();
        check("prio e_instr", e_instr, 32'hBB);
        check("prio e_a3", 32'(e_a3), 7);
        check("prio m_instr", m_instr, 0);
        check("prio bubble_cnt", 32'(bubble_cnt), 3);

        // Illegal request: de_stall without fd_stall still holds the front end
        fd_stall = 0; em_stall = 0; de_stall = 1;
        $display("note: protocol violation driven (de_stall without fd_stall)");
        tick();
        check("viol pc held", pc, 32'h300C);
        check("viol d_instr held", d_instr, 32'hCC);
        check("viol e_instr bubble", e_instr, 0);
        check("viol e_pc", e_pc, 32'h3008);
        check("viol bubble_cnt", 32'(bubble_cnt), 4);

        // Reset in the middle of an E/M stall
        fd_stall = 1; em_stall = 1; de_stall = 0; reset = 0;
        tick();
        check("rst-stall pc", pc, 32'h3000);
        check("rst-stall d_instr", d_instr, 0);
        check("rst-stall e_instr", e_instr, 0);
        check("rst-stall e_pc", e_pc, 32'h3000);
        check("rst-stall bubble_cnt", 32'(bubble_cnt), 0);
        reset = 1; fd_stall = 0; em_stall = 0; npc = 32'h3004;
        tick();
        check("rst-stall released pc", pc, 32'h3004);

        // Counter wrap: 17 stall cycles on a 4-bit counter
        fd_stall = 1;
        for (int i = 0; i < 17; i++) tick();
        check("wrap stall_cnt", 32'(stall_cnt), 1);
        check("wrap bubble_cnt", 32'(bubble_cnt), 0);

        // Random stimulus against the model
        reset = 0; fd_stall = 0; model_step(); tick();
        compare_all();
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 49) != 0);
            npc         = $urandom;
            f_instr     = $urandom;
            d_rs_val    = $urandom;
            d_rt_val    = $urandom;
            d_imm       = $urandom;
            d_a3_in     = 5'($urandom);
            e_alu       = $urandom;
            e_rt_val_in = $urandom;
            m_out_in    = $urandom;
            fd_stall    = ($urandom_range(0, 2) == 0);
            de_stall    = fd_stall && ($urandom_range(0, 1) == 0);
            em_stall    = fd_stall && ($urandom_range(0, 3) == 0);
            model_step();
            tick();
            compare_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_regs.md
Name: pipe_regs

Overview:
- Holds the PC and the four inter-stage registers (F/D, D/E, E/M, M/W) of the 5-stage MIPS pipeline.
- Consumes the stall requests produced by the hazard unit (fd_stall, de_stall, em_stall) and turns them into register holds and bubble insertion.
- Supplies the d_/e_/m_/w_ stage payloads that the hazard unit, forwarding muxes and the GRF write port read back.
- Keeps stall and bubble performance counters.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset
CNT_W, 32, width of the stall/bubble counters

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low; reset==0 at a rising edge resets all state
npc  in  32  next PC from the NPC unit
f_instr  in  32  instruction fetched at pc
d_rs_val  in  32  forwarded rs operand from D stage
d_rt_val  in  32  forwarded rt operand from D stage
d_imm  in  32  extended immediate from D stage
d_a3_in  in  5  destination register decoded in D (0 = none)
e_alu  in  32  ALU result from E stage
e_rt_val_in  in  32  forwarded rt value in E (store data)
m_out_in  in  32  M stage result (load data or passed ALU result)
fd_stall  in  1  hold PC and F/D
de_stall  in  1  bubble into D/E
em_stall  in  1  hold D/E, bubble into E/M
pc  out  32  current fetch PC
d_instr, d_pc  out  32 each  F/D contents
e_instr, e_pc, e_rs_val, e_rt_val, e_imm  out  32 each  D/E contents
e_a3  out  5  D/E destination
m_instr, m_pc, m_alu, m_rt_val  out  32 each  E/M contents
m_a3  out  5  E/M destination
w_instr, w_pc, w_data  out  32 each  M/W contents
w_a3  out  5  M/W destination (GRF write address)
stall_cnt  out  CNT_W  cycles with fd_stall==1
bubble_cnt  out  CNT_W  bubbles inserted (D/E or E/M)

Behaviour:
- Reset (reset==0 at a clock edge):
  - pc=PC_RESET.
  - Every stage instr/data/a3 output = 0; every stage pc output = PC_RESET.
  - Both counters = 0.
  - Reset overrides all stall inputs. Asserting reset mid-stall cancels the stall state the same cycle; nothing is held across reset.
- Normal cycle (no stall), per rising edge:
  - pc<=npc.
  - F/D<=(f_instr, pc).
  - D/E<=F/D outputs plus d_* inputs; e_a3<=d_a3_in.
  - E/M<=D/E outputs plus e_alu, e_rt_val_in.
  - M/W<=E/M outputs plus m_out_in.
  - Latency of 1 cycle per stage.
- fd_stall==1: pc and F/D hold their values.
- de_stall==1 (em_stall==0):
  - D/E loads a bubble: e_instr=0, e_rs_val=e_rt_val=e_imm=0, e_a3=0, e_pc=d_pc.
  - E/M and M/W advance normally.
- em_stall==1:
  - pc, F/D and D/E hold.
  - E/M loads a bubble: m_instr=0, m_alu=m_rt_val=0, m_a3=0, m_pc=e_pc.
  - M/W advances normally.
- Simultaneous de_stall and em_stall: em_stall takes priority. D/E holds and is not bubbled; bubble_cnt increments by 1 only.
- de_stall or em_stall while fd_stall==0: this is a protocol violation. Required handling: treat fd_stall as asserted (pc and F/D hold). Bench must flag it.
- M/W never stalls. A bubble flows through as an all-zero instruction with a3=0, so it produces no GRF write.
- Counters:
  - stall_cnt+1 on each edge with fd_stall==1 (and reset==1).
  - bubble_cnt+1 on each edge where a D/E or E/M bubble is inserted.
  - Both wrap modulo 2^CNT_W with no saturation.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold reset=0 two cycles with npc=32'h1234, fd_stall=1 -> pc=32'h3000, all instr/a3 outputs 0, counters 0; first edge after reset=1 with npc=32'h3004 -> pc=32'h3004, d_pc=32'h3000.
- Free flow: feed f_instr 0x11,0x22,0x33,0x44 on consecutive cycles, no stalls -> 0x11 appears on d_instr, e_instr, m_instr, w_instr on edges 1..4 respectively; d_a3_in=5'd8 with 0x11 -> w_a3=8 on edge 4.
- Load-use: fd_stall=de_stall=1 for one cycle with d_instr=0xAA, pc=32'h3008 -> pc, d_instr unchanged; e_instr=0, e_a3=0, e_pc=d_pc; next cycle stalls low -> e_instr=0xAA; stall_cnt=1, bubble_cnt=1.
- E/M stall: fd_stall=em_stall=1 for 2 cycles with e_instr=0xBB, m_a3 prior=9 -> e_instr stays 0xBB both cycles; m_instr=0, m_a3=0; w_a3=9 then 0; bubble_cnt=2, stall_cnt=2.
- Priority: fd_stall=de_stall=em_stall=1 for one cycle -> D/E holds (not zeroed), E/M bubbled, bubble_cnt+1.
- Reset mid-stall and wrap: reset=0 during an em_stall -> all stages cleared; with CNT_W=4, 17 stall cycles -> stall_cnt=1.
